rect_scan_gen: RTL and testbench



---
 rtl/rect_scan_gen.sv | 200 ++++++++++++++++++++
 tb/tb_rect_scan_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rect_scan_gen.sv
// rect_scan_gen: scans a programmable WxH rectangle at any origin, one pixel
// per valid/ready handshake, in fill or outline mode.
//
// Ports
//   clk, resetn                  clock (rising edge), async active-low reset
//   start                        pulse; latches origin/size/mode when idle
//   xOrigin, yOrigin             top-left corner
//   width, height                rectangle size; a zero in either is an empty scan
//   mode                         0 = fill, 1 = outline (border pixels only)
//   ready                        consumer accepts the current pixel
//   x, y                         registered pixel coordinate (wraps mod 2^XW / 2^YW)
//   addr                         registered row*width+col (sprite ROM index)
//   valid                        x/y/addr hold a pixel to plot
//   busy                         scan in progress
//   done                         one-cycle pulse when a scan ends
//
// Optional feature: define RECT_SCAN_CLIP_EN to skip pixels that fall off
// the SCREEN_W x SCREEN_H screen or whose coordinate sum overflows.
module rect_scan_gen #(
   parameter int XW       = 8,
   parameter int YW       = 7,
   parameter int DIMW     = 8,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [XW-1:0]     xOrigin,
   input  logic [YW-1:0]     yOrigin,
   input  logic [DIMW-1:0]   width,
   input  logic [DIMW-1:0]   height,
   input  logic              mode,
   input  logic              ready,
   output logic [XW-1:0]     x,
   output logic [YW-1:0]     y,
   output logic [2*DIMW-1:0] addr,
   output logic              valid,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

   state_t            state_q, state_d;
   logic [XW-1:0]     xo_q, xo_d;
   logic [YW-1:0]     yo_q, yo_d;
   logic [DIMW-1:0]   w_q, w_d, h_q, h_d;
   logic              mode_q, mode_d;
   logic [DIMW-1:0]   col_q, col_d, row_q, row_d;
   logic [2*DIMW-1:0] addr_q, addr_d;
   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic              valid_q, valid_d;

   // next pixel position, committed into the registers only when load=1
   logic              load;
   logic [DIMW-1:0]   col_n, row_n;
   logic [2*DIMW-1:0] addr_n;
   logic [XW-1:0]     x_n;
   logic [YW-1:0]     y_n;
   logic              pix_ok;
   logic              last_pix;

`ifdef RECT_SCAN_CLIP_EN
   // Wide sums so that overflow past XW/YW is visible to the clip test.
   logic [31:0] sx, sy;
   always_comb begin
      sx     = 32'(xo_d) + 32'(col_n);
      sy     = 32'(yo_d) + 32'(row_n);
      x_n    = sx[XW-1:0];
      y_n    = sy[YW-1:0];
      pix_ok = (sx < 32'(SCREEN_W)) && (sx < (32'd1 << XW)) &&
               (sy < 32'(SCREEN_H)) && (sy < (32'd1 << YW));
   end
`else
   always_comb begin
      x_n    = xo_d + XW'(col_n);
      y_n    = yo_d + YW'(row_n);
      pix_ok = 1'b1;
   end
   logic unused_screen;
   assign unused_screen = (SCREEN_W > 0) ^ (SCREEN_H > 0);
`endif

   assign last_pix = (row_q == h_q - DIMW'(1)) && (col_q == w_q - DIMW'(1));

   always_comb begin
      state_d = state_q;
      xo_d    = xo_q;
      yo_d    = yo_q;
      w_d     = w_q;
      h_d     = h_q;
      mode_d  = mode_q;
      col_d   = col_q;
      row_d   = row_q;
      addr_d  = addr_q;
      x_d     = x_q;
      y_d     = y_q;
      valid_d = valid_q;
      load    = 1'b0;
      col_n   = col_q;
      row_n   = row_q;
      addr_n  = addr_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (width != '0 && height != '0) begin
                  xo_d    = xOrigin;
                  yo_d    = yOrigin;
                  w_d     = width;
                  h_d     = height;
                  mode_d  = mode;
                  col_n   = '0;
                  row_n   = '0;
                  addr_n  = '0;
                  load    = 1'b1;
                  state_d = SCAN;
               end else begin
                  state_d = FIN;
               end
            end
         end
         SCAN: begin
            // A clipped (invalid) pixel advances without waiting for ready.
            if (!valid_q || ready) begin
               if (last_pix) begin
                  valid_d = 1'b0;
                  state_d = FIN;
               end else begin
                  load = 1'b1;
                  if (col_q == w_q - DIMW'(1)) begin
                     col_n  = '0;
                     row_n  = row_q + DIMW'(1);
                     addr_n = addr_q + (2*DIMW)'(1);
                  end else if (mode_q && col_q == '0 && row_q != '0 &&
                               row_q != h_q - DIMW'(1)) begin
                     // outline interior row: jump straight to the right edge
                     col_n  = w_q - DIMW'(1);
                     addr_n = addr_q + (2*DIMW)'(w_q - DIMW'(1));
                  end else begin
                     col_n  = col_q + DIMW'(1);
                     addr_n = addr_q + (2*DIMW)'(1);
                  end
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (load) begin
         col_d   = col_n;
         row_d   = row_n;
         addr_d  = addr_n;
         x_d     = x_n;
         y_d     = y_n;
         valid_d = pix_ok;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         xo_q    <= '0;
         yo_q    <= '0;
         w_q     <= '0;
         h_q     <= '0;
         mode_q  <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
         addr_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         xo_q    <= xo_d;
         yo_q    <= yo_d;
         w_q     <= w_d;
         h_q     <= h_d;
         mode_q  <= mode_d;
         col_q   <= col_d;
         row_q   <= row_d;
         addr_q  <= addr_d;
         x_q     <= x_d;
         y_q     <= y_d;
         valid_q <= valid_d;
      end
   end

   assign x     = x_q;
   assign y     = y_q;
   assign addr  = addr_q;
   assign valid = valid_q;
   assign busy  = (state_q == SCAN);
   assign done  = (state_q == FIN);

endmodule

// File: tb/tb_rect_scan_gen.sv
// Directed bench for rect_scan_gen: fill, stalled fill, outline, empty,
// coordinate wrap / clip, start-while-busy and mid-scan reset.
module tb_rect_scan_gen;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  xOrigin = '0;
   logic [6:0]  yOrigin = '0;
   logic [7:0]  width = '0;
   logic [7:0]  height = '0;
   logic        mode = 1'b0;
   logic        ready = 1'b1;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [15:0] addr;
   logic        valid, busy, done;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_x[64];
   int exp_y[64];
   int exp_a[64];

   rect_scan_gen dut (
      .clk(clk), .resetn(resetn), .start(start),
      .xOrigin(xOrigin), .yOrigin(yOrigin), .width(width), .height(height),
      .mode(mode), .ready(ready),
      .x(x), .y(y), .addr(addr), .valid(valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_exp(input int i, input int ex, input int ey, input int ea);
      exp_x[i] = ex;
      exp_y[i] = ey;
      exp_a[i] = ea;
   endtask

   // row-major fill, coordinates wrapped to 8/7 bits
   task automatic fill_exp(input int xo, input int yo, input int w, input int h);
      for (int r = 0; r < h && r * w < 64; r++)
         for (int c = 0; c < w && r * w + c < 64; c++)
            set_exp(r * w + c, (xo + c) & 255, (yo + r) & 127, r * w + c);
   endtask

   // exp_done < 0 means "one cycle after the last accepted pixel"
   task automatic run_scan(input string nm, input int xo, input int yo, input int w,
                           input int h, input int m, input int rpat,
                           input int n_exp, input int exp_done);
      int n, last_acc, done_cyc;
      xOrigin = xo[7:0];
      yOrigin = yo[6:0];
      width   = w[7:0];
      height  = h[7:0];
      mode    = m[0];
      start   = 1'b1;
      tick();
      start    = 1'b0;
      n        = 0;
      last_acc = -1;
      done_cyc = -1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         ready = (rpat == 0) || (cyc % 3 == 2);
         if (valid) begin
            if (n < n_exp) begin
               chk({nm, "_x"}, x, exp_x[n]);
               chk({nm, "_y"}, y, exp_y[n]);
               chk({nm, "_addr"}, addr, exp_a[n]);
               chk({nm, "_busy"}, busy, 1);
            end else begin
               chk({nm, "_extra_pixel"}, 1, 0);
            end
            if (ready) begin
               n++;
               last_acc = cyc;
            end
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
         tick();
      end
      ready = 1'b1;
      chk({nm, "_count"}, n, n_exp);
      chk({nm, "_done_cycle"}, done_cyc, (exp_done < 0) ? last_acc + 1 : exp_done);
      if (done_cyc >= 0) begin
         chk({nm, "_busy_at_done"}, busy, 0);
         chk({nm, "_valid_at_done"}, valid, 0);
      end
      tick();
      chk({nm, "_done_one_cycle"}, done, 0);
   endtask

   initial begin
      #12;
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_addr", addr, 0);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      tick();
      resetn = 1'b1;
      tick();

      fill_exp(36, 30, 3, 2);
      run_scan("fill3x2", 36, 30, 3, 2, 0, 0, 6, 6);
      run_scan("fill3x2_stall", 36, 30, 3, 2, 0, 1, 6, -1);

      set_exp(0, 0, 0, 0);  set_exp(1, 1, 0, 1);  set_exp(2, 2, 0, 2);
      set_exp(3, 3, 0, 3);  set_exp(4, 0, 1, 4);  set_exp(5, 3, 1, 7);
      set_exp(6, 0, 2, 8);  set_exp(7, 1, 2, 9);  set_exp(8, 2, 2, 10);
      set_exp(9, 3, 2, 11);
      run_scan("outline4x3", 0, 0, 4, 3, 1, 0, 10, 10);

      // outline with height 2 has no interior row: every pixel emitted
      fill_exp(10, 20, 3, 2);
      run_scan("outline3x2", 10, 20, 3, 2, 1, 0, 6, 6);

      run_scan("empty_w0", 3, 4, 0, 5, 0, 0, 0, 0);

`ifdef RECT_SCAN_CLIP_EN
      set_exp(0, 158, 118, 0);  set_exp(1, 159, 118, 1);
      set_exp(2, 158, 119, 4);  set_exp(3, 159, 119, 5);
      run_scan("clip4x4", 158, 118, 4, 4, 0, 0, 4, 16);
      run_scan("clip_all", 200, 10, 2, 2, 0, 0, 0, 4);
`else
      fill_exp(158, 118, 4, 4);
      run_scan("edge4x4", 158, 118, 4, 4, 0, 0, 16, 16);
      // x wraps 255->0 and y wraps 127->0
      fill_exp(254, 126, 3, 3);
      run_scan("wrap3x3", 254, 126, 3, 3, 0, 0, 9, 9);
`endif

      // 40x40 scan: start while busy must be ignored, then reset on pixel 3
      xOrigin = 8'd5;  yOrigin = 7'd6;  width = 8'd40;  height = 8'd40;
      mode = 1'b0;     ready = 1'b1;    start = 1'b1;
      tick();
      start = 1'b0;
      chk("big_p0_x", x, 5);
      chk("big_p0_addr", addr, 0);
      xOrigin = 8'd100;  width = 8'd3;  start = 1'b1;
      tick();
      start = 1'b0;
      chk("big_p1_x", x, 6);
      chk("big_p1_y", y, 6);
      chk("big_p1_addr", addr, 1);
      chk("big_p1_busy", busy, 1);
      tick();
      chk("big_p2_x", x, 7);
      chk("big_p2_addr", addr, 2);
      #2;
      resetn = 1'b0;
      #1;
      chk("midrst_x", x, 0);
      chk("midrst_y", y, 0);
      chk("midrst_addr", addr, 0);
      chk("midrst_valid", valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      tick();
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_done", done, 0);
         chk("post_rst_valid", valid, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
